// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

  // One extra bit over $clog2 so the bit index can reach WIDTH-1 for any WIDTH >= 1.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full-adder cell; the controller time-shares one instance across all bits.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: LSB-first operand shifting through one fa cell,
// with valid/ready handshakes on the operand and result sides.
//
//  state | meaning
//  IDLE  | waiting for operands, in_ready=1
//  RUN   | one bit per clock through the cell, WIDTH edges total
//  DONE  | result presented, held until out_ready
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [WIDTH-1:0] a_sh_n, b_sh_n, sum_sh_n;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             load, step;
  logic             cell_s, cell_c;

  fa u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (cell_s),
    .cout (cell_c)
  );

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    step     = 1'b0;
    a_sh_n   = '0;
    b_sh_n   = '0;
    sum_sh_n = '0;

    // Right shifts written bitwise so WIDTH=1 needs no zero-width slices.
    for (int i = 0; i < WIDTH - 1; i++) begin
      a_sh_n[i]   = a_sh[i+1];
      b_sh_n[i]   = b_sh[i+1];
      sum_sh_n[i] = sum_sh[i+1];
    end
    sum_sh_n[WIDTH-1] = cell_s;

    case (state)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        a_sh   <= a;
        b_sh   <= b;
        sum_sh <= '0;
        carry  <= cin;
        cnt    <= '0;
      end else if (step) begin
        a_sh   <= a_sh_n;
        b_sh   <= b_sh_n;
        sum_sh <= sum_sh_n;
        carry  <= cell_c;
        cnt    <= cnt + CW'(1);
      end
    end
  end

  // sum/cout are untouched outside RUN, so they hold their last result in IDLE.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_sh;
  assign cout      = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases plus a
// random scoreboard against plain a+b+cin arithmetic.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction. poke_at>0 pulses in_valid with a=8'h11 on that
  // post-accept cycle to confirm it is ignored.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                        input int stall, input int poke_at, input bit check_lat);
    logic [W:0] ref_full;
    int lat;
    ref_full = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, oc};
    chk("in_ready_before", in_ready, 1);
    in_valid = 1'b1; a = oa; b = ob; cin = oc;
    tick();
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 1;
    chk("busy_after_accept", busy, 1);
    while (!out_valid && lat < 40) begin
      if (lat == poke_at) begin in_valid = 1'b1; a = 8'h11; end
      chk("in_ready_run", in_ready, 0);
      tick();
      in_valid = 1'b0;
      lat++;
    end
    if (check_lat) chk("latency_edges_incl_accept", lat, W + 1);
    chk("out_valid_rise", out_valid, 1);
    if (!out_valid) return;
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_sum", sum, ref_full[W-1:0]);
      chk("stall_cout", cout, ref_full[W]);
      tick();
    end
    chk("sum", sum, ref_full[W-1:0]);
    chk("cout", cout, ref_full[W]);
    chk("busy_done", busy, 1);
    out_ready = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_sum_hold", sum, ref_full[W-1:0]);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_cout"}, cout, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    run_op(8'h5A, 8'h3C, 1'b0, 0, 0, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0, 0, 0, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 0, 1'b1);
    run_op(8'h00, 8'h00, 1'b1, 0, 0, 1'b1);

    // Backpressure in DONE for 5 cycles.
    run_op(8'hA7, 8'h6D, 1'b1, 5, 0, 1'b1);

    // in_valid pulse during RUN is ignored.
    run_op(8'h10, 8'h20, 1'b0, 0, 3, 1'b1);

    // Reset on the third RUN cycle aborts the operation.
    in_valid = 1'b1; a = 8'h55; b = 8'h66; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_run_reset");
    tick();
    check_reset_outputs("post_reset_idle");
    run_op(8'h80, 8'h80, 1'b0, 0, 0, 1'b1);

    // Reset while holding a result in DONE.
    in_valid = 1'b1; a = 8'hC3; b = 8'h3C; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) tick();
    chk("done_before_reset", out_valid, 1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    check_reset_outputs("done_reset");

    for (int n = 0; n < 200; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3), 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
